// File: rtl/aes_host_pkg.sv
// aes_host_pkg: shared types and sizes for the AES host stream controller.
package aes_host_pkg;
    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;
    localparam int NWORDS = BLK_W / WORD_W;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, RESP} host_state_t;
endpackage

// File: rtl/aes_blk_serdes.sv
// aes_blk_serdes: key/text block serializers and the result word deserializer.
module aes_blk_serdes
    import aes_host_pkg::*;
#(
    parameter int WORD_W = aes_host_pkg::WORD_W,
    parameter int BLK_W  = aes_host_pkg::BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [BLK_W-1:0]  key_i,
    input  logic [BLK_W-1:0]  text_i,
    output logic [WORD_W-1:0] key_word_o,
    output logic [WORD_W-1:0] text_word_o,
    input  logic              cap_clr_i,
    input  logic              cap_en_i,
    input  logic [WORD_W-1:0] cap_word_i,
    output logic [BLK_W-1:0]  cap_o
);
    localparam int NW    = BLK_W / WORD_W;
    localparam int IDX_W = $clog2(NW);

    logic [BLK_W-1:0] key_q, key_d, text_q, text_d, cap_q, cap_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Both blocks shift out most-significant word first.
    assign key_d  = load_i ? key_i  : shift_i ? {key_q[BLK_W-WORD_W-1:0], WORD_W'(0)}  : key_q;
    assign text_d = load_i ? text_i : shift_i ? {text_q[BLK_W-WORD_W-1:0], WORD_W'(0)} : text_q;
    assign key_word_o  = key_q[BLK_W-1 -: WORD_W];
    assign text_word_o = text_q[BLK_W-1 -: WORD_W];
    assign cap_o = cap_q;

    always_comb begin
        cap_d = cap_q;
        idx_d = idx_q;
        if (cap_clr_i) begin
            cap_d = '0;
            idx_d = '0;
        end else if (cap_en_i) begin
            cap_d[BLK_W-1-WORD_W*int'(idx_q) -: WORD_W] = cap_word_i;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= '0;
            text_q <= '0;
            cap_q  <= '0;
            idx_q  <= '0;
        end else begin
            key_q  <= key_d;
            text_q <= text_d;
            cap_q  <= cap_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/aes_host_stream_ctrl.sv
// aes_host_stream_ctrl: block-level request/response front end for the AES core word port.
module aes_host_stream_ctrl
    import aes_host_pkg::*;
#(
    parameter int WORD_W  = aes_host_pkg::WORD_W,
    parameter int BLK_W   = aes_host_pkg::BLK_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [BLK_W-1:0]  req_key_i,
    input  logic [BLK_W-1:0]  req_text_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BLK_W-1:0]  rsp_text_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic              aes_ld_o,
    output logic [WORD_W-1:0] aes_key_o,
    output logic [WORD_W-1:0] aes_text_o,
    input  logic              aes_done_i,
    input  logic [WORD_W-1:0] aes_text_i
);
    localparam int NW    = BLK_W / WORD_W;
    localparam int IDX_W = $clog2(NW);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    host_state_t       state_q, state_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              tout_q, tout_d;
    logic              accept, cap_en, load_last, cap_last, expire;
    logic [WORD_W-1:0] key_w, text_w;
    logic [BLK_W-1:0]  cap;

    assign req_ready_o   = state_q == IDLE;
    assign busy_o        = !req_ready_o;
    assign accept        = req_valid_i && req_ready_o;
    assign aes_ld_o      = state_q == LOAD;
    assign aes_key_o     = aes_ld_o ? key_w : '0;
    assign aes_text_o    = aes_ld_o ? text_w : '0;
    assign rsp_valid_o   = state_q == RESP;
    assign rsp_timeout_o = rsp_valid_o && tout_q;
    // The capture register is cleared on accept, so an aborted transaction reads back zero.
    assign rsp_text_o    = rsp_valid_o ? cap : '0;
    assign load_last     = widx_q == IDX_W'(NW - 1);
    assign cap_last      = widx_q == IDX_W'(NW - 2);
    assign expire        = to_q == TO_W'(TIMEOUT - 1);

    // One word index serves both the load burst and the remaining capture cycles.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        tout_d  = tout_q;
        to_d    = state_q == WAIT ? to_q + TO_W'(1) : '0;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    tout_d  = 1'b0;
                end
            end
            LOAD: begin
                widx_d = load_last ? '0 : widx_q + IDX_W'(1);
                if (load_last) state_d = WAIT;
            end
            WAIT: begin
                if (aes_done_i) begin
                    cap_en  = 1'b1;
                    state_d = CAPTURE;
                end else if (expire) begin
                    state_d = RESP;
                    tout_d  = 1'b1;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                widx_d = cap_last ? '0 : widx_q + IDX_W'(1);
                if (cap_last) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            widx_q  <= '0;
            to_q    <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            to_q    <= to_d;
            tout_q  <= tout_d;
        end
    end

    aes_blk_serdes #(.WORD_W(WORD_W), .BLK_W(BLK_W)) u_serdes (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .shift_i     (aes_ld_o),
        .key_i       (req_key_i),
        .text_i      (req_text_i),
        .key_word_o  (key_w),
        .text_word_o (text_w),
        .cap_clr_i   (accept),
        .cap_en_i    (cap_en),
        .cap_word_i  (aes_text_i),
        .cap_o       (cap)
    );
endmodule

// File: tb/tb_aes_host_stream_ctrl.sv
// tb_aes_host_stream_ctrl: scoreboard bench with a behavioural AES core word-port model.
module tb_aes_host_stream_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0, rsp_ready = 1'b1, aes_done = 1'b0;
    logic [127:0] req_key = '0, req_text = '0;
    logic [31:0]  aes_txt = '0;
    logic         req_ready_o, rsp_valid_o, rsp_timeout_o, busy_o, aes_ld_o;
    logic [127:0] rsp_text_o;
    logic [31:0]  aes_key_o, aes_text_o;

    aes_host_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_key_i(req_key), .req_text_i(req_text),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_text_o(rsp_text_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .aes_ld_o(aes_ld_o), .aes_key_o(aes_key_o), .aes_text_o(aes_text_o),
        .aes_done_i(aes_done), .aes_text_i(aes_txt)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0, nrsp = 0, hs_cyc = -1, t_acc = 0;
    logic [63:0]  ld_q[$];
    logic [128:0] sb_q[$];
    int           rise_q[$];
    logic [127:0] core_q[$];
    bit core_en = 1'b1, stray_ld = 1'b0, stray_cap = 1'b0;
    int core_dly = 3;

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Core model: after four ld words, waits core_dly cycles, then returns four result words.
    int nld = 0, ph = 0, cnt = 0, k = 0;
    logic [127:0] r = '0;
    initial forever begin
        @(negedge clk);
        aes_done = 1'b0;
        aes_txt  = '0;
        if (!rst) begin
            nld = 0;
            ph  = 0;
            continue;
        end
        if (ph == 1) begin
            cnt--;
            if (cnt == 0) begin
                aes_done = 1'b1;
                aes_txt  = r[127:96];
                rise_q.push_back(cyc + 4);
                k  = 1;
                ph = 2;
            end
        end else if (ph == 2) begin
            aes_done = stray_cap;
            aes_txt  = r[127-32*k -: 32];
            k++;
            if (k == 4) ph = 0;
        end else if (aes_ld_o) begin
            nld++;
            if (nld == 3 && stray_ld) begin
                aes_done = 1'b1;
                aes_txt  = 32'hdeadbeef;
            end
            if (nld == 4) begin
                nld = 0;
                if (core_en && core_q.size() > 0) begin
                    r   = core_q.pop_front();
                    cnt = core_dly;
                    ph  = 2'd1;
                end
            end
        end
    end

    // Monitor: samples after the drive edge, pops expectations when the DUT presents data.
    bit pv = 1'b0, phs = 1'b0;
    logic [128:0] last = '0;
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            pv  = 1'b0;
            phs = 1'b0;
            continue;
        end
        if (aes_ld_o) begin
            if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
            else chk("ld_words", {aes_key_o, aes_text_o}, ld_q.pop_front());
        end else chk("ld_idle_zero", {aes_key_o, aes_text_o}, 0);
        chk("busy", busy_o, !req_ready_o);
        if (pv) chk("rsp_hold", rsp_valid_o, !phs);
        if (rsp_valid_o) begin
            chk("ready_in_resp", req_ready_o, 0);
            if (!pv) begin
                if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", {rsp_timeout_o, rsp_text_o}, sb_q.pop_front());
                if (rise_q.size() == 0) chk("rise_unexpected", 1, 0);
                else chk("rsp_latency", cyc, rise_q.pop_front());
            end else chk("rsp_stable", {rsp_timeout_o, rsp_text_o}, last);
            last = {rsp_timeout_o, rsp_text_o};
        end
        phs = rsp_valid_o && rsp_ready;
        if (phs) begin
            hs_cyc = cyc;
            nrsp++;
        end
        pv = rsp_valid_o;
    end

    task automatic send(input logic [127:0] kk, input logic [127:0] pp, input logic [127:0] rr, input bit to);
        int n = 0;
        @(negedge clk);
        req_key   = kk;
        req_text  = pp;
        req_valid = 1'b1;
        while (!req_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", n < 300, 1);
        t_acc = cyc;
        for (int w = 0; w < 4; w++) ld_q.push_back({kk[127-32*w -: 32], pp[127-32*w -: 32]});
        sb_q.push_back(to ? {1'b1, 128'h0} : {1'b0, rr});
        if (to) rise_q.push_back(cyc + 5 + 64);
        else core_q.push_back(rr);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int c = 0;
        while (nrsp < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("rsp_count", nrsp, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ld", aes_ld_o, 0);
        chk("rst_text", rsp_text_o, 0);
        chk("rst_timeout", rsp_timeout_o, 0);
        @(negedge clk);
        rst = 1'b1;
        send(K, P, R, 0);
        wait_rsp(1);
        core_en = 1'b0;
        send(~K, ~P, '0, 1);
        wait_rsp(2);
        core_en = 1'b1;
        send(K, P, R, 0);
        wait_rsp(3);
        rsp_ready = 1'b0;
        send(K, P, R, 0);
        for (int i = 0; i < 500 && !rsp_valid_o; i++) @(negedge clk);
        fork
            begin
                repeat (10) @(negedge clk);
                rsp_ready = 1'b1;
            end
            send(128'h1, 128'h2, 128'hcafef00d_11112222_33334444_55556666, 0);
        join
        chk("accept_after_hs", t_acc, hs_cyc + 1);
        wait_rsp(5);
        stray_ld  = 1'b1;
        stray_cap = 1'b1;
        send(K, P, R, 0);
        wait_rsp(6);
        stray_ld  = 1'b0;
        stray_cap = 1'b0;
        send(K, P, R, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_ld", aes_ld_o, 0);
        ld_q.delete();
        sb_q.delete();
        core_q.delete();
        rise_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready", req_ready_o, 1);
        chk("rel_valid", rsp_valid_o, 0);
        chk("rel_busy", busy_o, 0);
        send(K, P, R, 0);
        wait_rsp(7);
        core_dly = 1;
        send(128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3, 128'h10, 128'h01020304_05060708_090a0b0c_0d0e0f10, 0);
        send(128'h20, 128'he0e1e2e3_f0f1f2f3_01234567_89abcdef, 128'hfedcba98_76543210_0f0e0d0c_0b0a0908, 0);
        chk("b2b_accept", t_acc, hs_cyc + 1);
        wait_rsp(9);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
